// File: rtl/fft_direction_scheduler.sv
// Shares one runtime-configurable FFT core between a forward and an inverse requester.
// Define FFT_CFG_CACHE_EN to skip the config word when the direction is unchanged.
module fft_direction_scheduler #(
    parameter int                     CONFIG_WIDTH = 16,
    parameter int                     SCALE_WIDTH  = 6,
    parameter logic [SCALE_WIDTH-1:0] SCALE_FWD    = 6'b101010,
    parameter logic [SCALE_WIDTH-1:0] SCALE_INV    = 6'b010101,
    parameter int                     FRAME_LEN    = 1024,
    parameter int                     CNT_WIDTH    = 11
) (
    input  logic                    s_axis_video_aclk,
    input  logic                    s_axis_video_areset,
    input  logic                    fwd_req,
    output logic                    fwd_ack,
    input  logic                    inv_req,
    output logic                    inv_ack,
    output logic [CONFIG_WIDTH-1:0] cfg_tdata,
    output logic                    cfg_tvalid,
    input  logic                    cfg_tready,
    input  logic                    din_tvalid,
    input  logic                    din_tready,
    output logic                    grant_fwd,
    output logic                    grant_inv,
    input  logic                    dout_tvalid,
    input  logic                    dout_tready,
    input  logic                    dout_tlast,
    output logic                    busy,
    output logic                    cur_dir
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CFG   = 2'd1,
        GRANT = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] FRAME_LAST = CNT_WIDTH'(FRAME_LEN - 1);

    function automatic logic [CONFIG_WIDTH-1:0] cfg_word(input logic dir);
        logic [CONFIG_WIDTH-1:0] w;
        w                = {CONFIG_WIDTH{1'b0}};
        w[0]             = dir;
        w[SCALE_WIDTH:1] = dir ? SCALE_FWD : SCALE_INV;
        return w;
    endfunction

    state_t                  state_r, state_s;
    logic                    dir_r, dir_s;
    logic                    prio_fwd_r, prio_fwd_s;
    logic [CNT_WIDTH-1:0]    cnt_r, cnt_s;
    logic [CONFIG_WIDTH-1:0] cfg_tdata_r, cfg_tdata_s;
    logic                    cfg_tvalid_r, cfg_tvalid_s;
    logic                    grant_fwd_r, grant_fwd_s;
    logic                    grant_inv_r, grant_inv_s;
    logic                    fwd_ack_r, fwd_ack_s;
    logic                    inv_ack_r, inv_ack_s;
    logic                    busy_r, busy_s;
    logic                    cur_dir_r, cur_dir_s;

    logic req_any_s, sel_fwd_s, in_beat_s, out_last_s, cache_hit_s;

    assign req_any_s  = fwd_req | inv_req;
    // Round-robin only matters when both requesters are waiting.
    assign sel_fwd_s  = fwd_req & (~inv_req | prio_fwd_r);
    assign in_beat_s  = din_tvalid & din_tready;
    assign out_last_s = dout_tvalid & dout_tready & dout_tlast;

`ifdef FFT_CFG_CACHE_EN
    logic cache_valid_r, cache_valid_s;
    logic cache_dir_r, cache_dir_s;
    assign cache_hit_s = cache_valid_r & (cache_dir_r == sel_fwd_s);
`else
    assign cache_hit_s = 1'b0;
`endif

    // State register and registered outputs; reset abandons any transform in flight.
    always_ff @(posedge s_axis_video_aclk) begin
        if (s_axis_video_areset) begin
            state_r       <= IDLE;
            dir_r         <= 1'b0;
            prio_fwd_r    <= 1'b1;
            cnt_r         <= {CNT_WIDTH{1'b0}};
            cfg_tdata_r   <= {CONFIG_WIDTH{1'b0}};
            cfg_tvalid_r  <= 1'b0;
            grant_fwd_r   <= 1'b0;
            grant_inv_r   <= 1'b0;
            fwd_ack_r     <= 1'b0;
            inv_ack_r     <= 1'b0;
            busy_r        <= 1'b0;
            cur_dir_r     <= 1'b0;
`ifdef FFT_CFG_CACHE_EN
            cache_valid_r <= 1'b0;
            cache_dir_r   <= 1'b0;
`endif
        end else begin
            state_r       <= state_s;
            dir_r         <= dir_s;
            prio_fwd_r    <= prio_fwd_s;
            cnt_r         <= cnt_s;
            cfg_tdata_r   <= cfg_tdata_s;
            cfg_tvalid_r  <= cfg_tvalid_s;
            grant_fwd_r   <= grant_fwd_s;
            grant_inv_r   <= grant_inv_s;
            fwd_ack_r     <= fwd_ack_s;
            inv_ack_r     <= inv_ack_s;
            busy_r        <= busy_s;
            cur_dir_r     <= cur_dir_s;
`ifdef FFT_CFG_CACHE_EN
            cache_valid_r <= cache_valid_s;
            cache_dir_r   <= cache_dir_s;
`endif
        end
    end

    // Next-state logic; tlast is only recognised once the input frame is complete.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    if (req_any_s) state_s = cache_hit_s ? GRANT : CFG;
                     else           state_s = IDLE;
            CFG:     if (cfg_tready) state_s = GRANT;
                     else            state_s = CFG;
            GRANT:   if (in_beat_s && cnt_r == FRAME_LAST) state_s = DRAIN;
                     else                                  state_s = GRANT;
            DRAIN:   if (out_last_s) state_s = IDLE;
                     else            state_s = DRAIN;
            default: state_s = IDLE;
        endcase
    end

    // Next values of the registered outputs, counter, pointer and cache.
    always_comb begin
        dir_s        = dir_r;
        prio_fwd_s   = prio_fwd_r;
        cnt_s        = cnt_r;
        cfg_tdata_s  = cfg_tdata_r;
        cfg_tvalid_s = cfg_tvalid_r;
        grant_fwd_s  = grant_fwd_r;
        grant_inv_s  = grant_inv_r;
        fwd_ack_s    = 1'b0;
        inv_ack_s    = 1'b0;
        cur_dir_s    = cur_dir_r;
`ifdef FFT_CFG_CACHE_EN
        cache_valid_s = cache_valid_r;
        cache_dir_s   = cache_dir_r;
`endif
        case (state_r)
            IDLE: begin
                if (req_any_s) begin
                    dir_s      = sel_fwd_s;
                    prio_fwd_s = ~sel_fwd_s;
                    cnt_s      = {CNT_WIDTH{1'b0}};
                    if (cache_hit_s) begin
                        grant_fwd_s = sel_fwd_s;
                        grant_inv_s = ~sel_fwd_s;
                    end else begin
                        cfg_tvalid_s = 1'b1;
                        cfg_tdata_s  = cfg_word(sel_fwd_s);
                    end
                end else begin
                    dir_s = dir_r;
                end
            end
            CFG: begin
                if (cfg_tready) begin
                    cfg_tvalid_s = 1'b0;
                    grant_fwd_s  = dir_r;
                    grant_inv_s  = ~dir_r;
                    cnt_s        = {CNT_WIDTH{1'b0}};
                    cur_dir_s    = dir_r;
`ifdef FFT_CFG_CACHE_EN
                    cache_valid_s = 1'b1;
                    cache_dir_s   = dir_r;
`endif
                end else begin
                    cfg_tvalid_s = 1'b1;
                end
            end
            GRANT: begin
                if (in_beat_s) begin
                    cnt_s = cnt_r + CNT_WIDTH'(1);
                    if (cnt_r == FRAME_LAST) begin
                        grant_fwd_s = 1'b0;
                        grant_inv_s = 1'b0;
                    end else begin
                        grant_fwd_s = grant_fwd_r;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            DRAIN: begin
                if (out_last_s) begin
                    fwd_ack_s = dir_r;
                    inv_ack_s = ~dir_r;
                    cur_dir_s = dir_r;
                end else begin
                    cur_dir_s = cur_dir_r;
                end
            end
            default: begin
                cfg_tvalid_s = 1'b0;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    assign cfg_tdata  = cfg_tdata_r;
    assign cfg_tvalid = cfg_tvalid_r;
    assign grant_fwd  = grant_fwd_r;
    assign grant_inv  = grant_inv_r;
    assign fwd_ack    = fwd_ack_r;
    assign inv_ack    = inv_ack_r;
    assign busy       = busy_r;
    assign cur_dir    = cur_dir_r;

endmodule

// File: tb/tb_fft_direction_scheduler.sv
// Scoreboard bench for fft_direction_scheduler: stimulus queues expected events,
// a negedge monitor pops and compares config words, grants, beat counts and acks.
module tb_fft_direction_scheduler;

    localparam int FRAME_LEN = 1024;
    localparam int EV_CFG    = 0;
    localparam int EV_GRANT  = 1;
    localparam int EV_BEATS  = 2;
    localparam int EV_ACK    = 3;

    typedef struct {
        int          kind;
        logic [15:0] val;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fwd_req = 1'b0, inv_req = 1'b0;
    logic        fwd_ack, inv_ack;
    logic [15:0] cfg_tdata;
    logic        cfg_tvalid;
    logic        cfg_tready = 1'b1;
    logic        din_tvalid = 1'b0, din_tready = 1'b0;
    logic        grant_fwd, grant_inv;
    logic        dout_tvalid = 1'b0, dout_tready = 1'b1, dout_tlast = 1'b0;
    logic        busy, cur_dir;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    logic        m_prev_g = 1'b0, m_prev_cfg_v = 1'b0, m_g;
    logic [15:0] m_prev_cfg_d = 16'd0;
    int          m_beats = 0;

    always #5 clk = ~clk;

    fft_direction_scheduler dut (
        .s_axis_video_aclk   (clk),
        .s_axis_video_areset (rst),
        .fwd_req             (fwd_req),
        .fwd_ack             (fwd_ack),
        .inv_req             (inv_req),
        .inv_ack             (inv_ack),
        .cfg_tdata           (cfg_tdata),
        .cfg_tvalid          (cfg_tvalid),
        .cfg_tready          (cfg_tready),
        .din_tvalid          (din_tvalid),
        .din_tready          (din_tready),
        .grant_fwd           (grant_fwd),
        .grant_inv           (grant_inv),
        .dout_tvalid         (dout_tvalid),
        .dout_tready         (dout_tready),
        .dout_tlast          (dout_tlast),
        .busy                (busy),
        .cur_dir             (cur_dir)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL timeout_%s: event not seen, required within bound", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input int k, input logic [15:0] v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic push_xfer(input bit fwd, input bit with_cfg);
        if (with_cfg) push_ev(EV_CFG, fwd ? 16'h0055 : 16'h002A);
        push_ev(EV_GRANT, fwd ? 16'h0001 : 16'h0002);
        push_ev(EV_BEATS, 16'(FRAME_LEN));
        push_ev(EV_ACK, fwd ? 16'h0001 : 16'h0002);
    endtask

    task automatic see_ev(input int k, input logic [15:0] v);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind %0d value %h, required no event", k, v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val !== v) begin
                errors++;
                $display("FAIL event_order: got kind %0d value %h, required kind %0d value %h",
                         k, v, e.kind, e.val);
            end
        end
    endtask

    task automatic chk_zero(input string name);
        chk(name, {9'd0, cfg_tdata, cfg_tvalid, grant_fwd, grant_inv,
                   fwd_ack, inv_ack, busy, cur_dir}, 32'd0);
    endtask

    task automatic wait_grant();
        int guard;
        guard = 0;
        while (!(grant_fwd || grant_inv) && guard < 200) begin
            step();
            guard++;
        end
        if (!(grant_fwd || grant_inv)) timeout("grant");
    endtask

    // Feeds one input frame, extra beats in DRAIN, untagged then tagged output beats.
    task automatic serve(input bit tlast_in_grant, input int extra);
        int guard;
        wait_grant();
        guard = 0;
        while ((grant_fwd || grant_inv) && guard < 8000) begin
            din_tvalid  = (guard % 5) != 2;
            din_tready  = (guard % 3) != 1;
            dout_tvalid = tlast_in_grant && ((guard % 4) == 0);
            dout_tlast  = dout_tvalid;
            step();
            guard++;
        end
        dout_tvalid = 1'b0;
        dout_tlast  = 1'b0;
        din_tvalid  = 1'b1;
        din_tready  = 1'b1;
        repeat (extra) step();
        din_tvalid  = 1'b0;
        dout_tvalid = 1'b1;
        repeat (2) step();
        dout_tlast = 1'b1;
        step();
        dout_tvalid = 1'b0;
        dout_tlast  = 1'b0;
        guard = 0;
        while (!(fwd_ack || inv_ack) && guard < 20) begin
            step();
            guard++;
        end
        if (!(fwd_ack || inv_ack)) timeout("ack");
    endtask

    always @(negedge clk) begin
        m_g = grant_fwd | grant_inv;
        if (fwd_ack || inv_ack) begin
            see_ev(EV_ACK, {14'd0, inv_ack, fwd_ack});
            chk("ack_grant_overlap", {30'd0, grant_inv, grant_fwd}, 32'd0);
        end
        if (cfg_tvalid && !m_prev_cfg_v) see_ev(EV_CFG, cfg_tdata);
        if (cfg_tvalid && m_prev_cfg_v) chk("cfg_tdata_stable", {16'd0, cfg_tdata}, {16'd0, m_prev_cfg_d});
        if (m_g && !m_prev_g) begin
            see_ev(EV_GRANT, {14'd0, grant_inv, grant_fwd});
            m_beats = 0;
        end
        if (m_g && din_tvalid && din_tready) m_beats++;
        if (!m_g && m_prev_g) see_ev(EV_BEATS, 16'(m_beats));
        m_prev_g     = m_g;
        m_prev_cfg_v = cfg_tvalid;
        m_prev_cfg_d = cfg_tdata;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) step();
        chk_zero("reset_outputs");
        rst = 1'b0;
        step();

        // Forward transform with the config channel always ready.
        fwd_req = 1'b1;
        push_xfer(1'b1, 1'b1);
        step();
        chk("t1_cfg_valid", {31'd0, cfg_tvalid}, 32'd1);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        step();
        chk("t1_cfg_drop", {31'd0, cfg_tvalid}, 32'd0);
        chk("t1_grant_fwd", {30'd0, grant_inv, grant_fwd}, 32'd1);
        serve(1'b0, 0);
        fwd_req = 1'b0;
        chk("t1_busy_idle", {31'd0, busy}, 32'd0);
        chk("t1_cur_dir", {31'd0, cur_dir}, 32'd1);
        step();
        chk("t1_busy_after", {31'd0, busy}, 32'd0);

        // Inverse transform with config back-pressure.
        cfg_tready = 1'b0;
        inv_req    = 1'b1;
        push_xfer(1'b0, 1'b1);
        step();
        chk("t2_cfg_valid", {31'd0, cfg_tvalid}, 32'd1);
        repeat (5) begin
            chk("t2_no_grant", {30'd0, grant_inv, grant_fwd}, 32'd0);
            chk("t2_cfg_hold", {31'd0, cfg_tvalid}, 32'd1);
            chk("t2_cur_dir_old", {31'd0, cur_dir}, 32'd1);
            step();
        end
        cfg_tready = 1'b1;
        step();
        chk("t2_grant_inv", {30'd0, grant_inv, grant_fwd}, 32'd2);
        chk("t2_cfg_drop", {31'd0, cfg_tvalid}, 32'd0);
        chk("t2_cur_dir_new", {31'd0, cur_dir}, 32'd0);
        serve(1'b0, 0);
        inv_req = 1'b0;
        step();

        // Both requesters held: grants alternate starting with forward.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) push_xfer(i % 2 == 0, 1'b1);
        fwd_req = 1'b1;
        inv_req = 1'b1;
        for (int i = 0; i < 4; i++) serve(1'b0, 0);
        fwd_req = 1'b0;
        inv_req = 1'b0;
        step();

        // Reset after 100 beats abandons the transform without an ack.
        fwd_req = 1'b1;
        push_ev(EV_CFG, 16'h0055);
        push_ev(EV_GRANT, 16'h0001);
        push_ev(EV_BEATS, 16'd100);
        wait_grant();
        din_tvalid = 1'b1;
        din_tready = 1'b1;
        repeat (100) step();
        din_tvalid = 1'b0;
        rst        = 1'b1;
        fwd_req    = 1'b0;
        step();
        chk_zero("t4_reset_midgrant");
        rst = 1'b0;
        step();
        fwd_req = 1'b1;
        push_xfer(1'b1, 1'b1);
        step();
        chk("t4_restart_cfg", {31'd0, cfg_tvalid}, 32'd1);
        serve(1'b0, 0);
        fwd_req = 1'b0;
        step();

        // Extra input beats in DRAIN and tlast during GRANT are ignored.
        inv_req = 1'b1;
        push_xfer(1'b0, 1'b1);
        serve(1'b1, 4);
        inv_req = 1'b0;
        step();

        // Back-to-back forward transforms, with and without the config cache.
        rst = 1'b1;
        step();
        rst = 1'b0;
        fwd_req = 1'b1;
        push_xfer(1'b1, 1'b1);
        serve(1'b0, 0);
        fwd_req = 1'b0;
        step();
`ifdef FFT_CFG_CACHE_EN
        push_xfer(1'b1, 1'b0);
`else
        push_xfer(1'b1, 1'b1);
`endif
        fwd_req = 1'b1;
        step();
`ifdef FFT_CFG_CACHE_EN
        chk("t6_cache_grant", {30'd0, grant_inv, grant_fwd}, 32'd1);
        chk("t6_cache_no_cfg", {31'd0, cfg_tvalid}, 32'd0);
`else
        chk("t6_cfg_again", {31'd0, cfg_tvalid}, 32'd1);
        chk("t6_no_early_grant", {30'd0, grant_inv, grant_fwd}, 32'd0);
`endif
        serve(1'b0, 0);
        fwd_req = 1'b0;
        repeat (5) step();

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
